instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 32, number of words in program memory.
REQ-003 SHALL have parameter RESET_PC, default 32'h0040_0000, PC value after reset and base of valid fetch range.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 Stall  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-007 RedirectValid  input  1  branch/jump taken this cycle.
REQ-008 RedirectTarget  input  DATA_WIDTH  new PC when RedirectValid=1.
REQ-009 Instruction  input  DATA_WIDTH  combinational word returned by program memory for PC.
REQ-010 PC  output  DATA_WIDTH  current fetch address, drives program memory Address.
REQ-011 IFID_Instruction  output  DATA_WIDTH  registered instruction to decode.
REQ-012 IFID_PCPlus4  output  DATA_WIDTH  registered PC+4 of that instruction.
REQ-013 IFID_Valid  output  1  IF/ID holds a real instruction.
REQ-014 Fault  output  1  sticky fetch fault flag.
REQ-015 FaultAddr  output  DATA_WIDTH  PC or target that caused the fault.
REQ-016 InstrCount  output  16  count of instructions latched into IF/ID, saturating.

Function
REQ-017 FSM SHALL have states BOOT, RUN, FAULT.
REQ-018 BOOT SHALL last exactly one cycle after reset release: PC held at RESET_PC, IF/ID unchanged, then transition to RUN unconditionally.
REQ-019 In RUN, per-edge priority SHALL be: fault detection > RedirectValid > Stall > sequential fetch.
REQ-020 Range check: PC is in range iff RESET_PC <= PC <= RESET_PC+4*(MEMORY_DEPTH-1), unsigned compare, and PC[1:0]=0.
REQ-021 If PC is out of range in RUN and RedirectValid=0, next state SHALL be FAULT; FaultAddr<=PC; IFID_Valid<=0; PC held.
REQ-022 If RedirectValid=1 and RedirectTarget[1:0]!=0, next state SHALL be FAULT; FaultAddr<=RedirectTarget; IFID_Valid<=0; PC held.
REQ-023 Valid redirect SHALL set PC<=RedirectTarget, IFID_Instruction<=0, IFID_PCPlus4<=0, IFID_Valid<=0 (squash), regardless of Stall.
REQ-024 Stall without redirect SHALL hold PC, IF/ID registers, and InstrCount unchanged.
REQ-025 Sequential fetch SHALL set PC<=PC+4 (mod 2^DATA_WIDTH), IFID_Instruction<=Instruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1, InstrCount<=InstrCount+1.
REQ-026 InstrCount SHALL saturate at 16'hFFFF, never wrap.
REQ-027 PC wrap from 32'hFFFF_FFFC to 0 SHALL occur arithmetically; the resulting PC is out of range and faults next cycle per REQ-021.
REQ-028 FAULT SHALL be absorbing until reset: PC, FaultAddr held; Fault=1; IFID_Valid=0; Stall and RedirectValid ignored.
REQ-029 Fault SHALL be registered, asserted the cycle after state enters FAULT.
REQ-030 PC SHALL be a register output; no combinational path from any input to PC.

Reset
REQ-031 reset=0 SHALL immediately force state=BOOT, PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, Fault=0, FaultAddr=0, InstrCount=0.
REQ-032 reset asserted mid-operation, including in FAULT or during Stall/redirect, SHALL behave identically to REQ-031.

Verification
REQ-033 Boot: release reset, Instruction=mem[word] -> cycle1 PC=0x0040_0000, IFID_Valid=0; cycle2 IFID_Instruction=mem[0], IFID_PCPlus4=0x0040_0004, PC=0x0040_0004, InstrCount=1.
REQ-034 Stall: RUN at PC=0x0040_0008, Stall=1 for 3 cycles -> PC, IF/ID, InstrCount unchanged; Stall=0 -> PC=0x0040_000C next edge.
REQ-035 Redirect with Stall: RedirectValid=1, Target=0x0040_0010, Stall=1 -> PC=0x0040_0010, IFID_Valid=0, IFID_Instruction=0; next edge IFID_PCPlus4=0x0040_0014.
REQ-036 Range fault: MEMORY_DEPTH=32, run to PC=0x0040_0080 -> next edge FAULT, FaultAddr=0x0040_0080, Fault=1, IFID_Valid=0; further Stall/Redirect ignored.
REQ-037 Misaligned fault: Target=0x0040_0006 -> FAULT, FaultAddr=0x0040_0006, PC unchanged.
REQ-038 Reset in FAULT and counter saturation (force InstrCount=16'hFFFF, fetch) -> reset clears all outputs per REQ-031; saturated count stays 16'hFFFF.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register and IF/ID pipeline register with a
// BOOT/RUN/FAULT controller that traps out-of-range or misaligned fetches.
module instruction_fetch_unit #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Stall,
   input  logic                  RedirectValid,
   input  logic [DATA_WIDTH-1:0] RedirectTarget,
   input  logic [DATA_WIDTH-1:0] Instruction,
   output logic [DATA_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0] IFID_Instruction,
   output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
   output logic                  IFID_Valid,
   output logic                  Fault,
   output logic [DATA_WIDTH-1:0] FaultAddr,
   output logic [15:0]           InstrCount
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [DATA_WIDTH-1:0] LAST_PC = RESET_PC + DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   pc_nxt;
   logic [DATA_WIDTH-1:0]   pc_plus4;
   logic [DATA_WIDTH-1:0]   instr_p1_nxt;
   logic [DATA_WIDTH-1:0]   pc4_p1_nxt;
   logic                    vld_p1_nxt;
   logic                    fault_nxt;
   logic [DATA_WIDTH-1:0]   faddr_nxt;
   logic [15:0]             cnt_nxt;
   logic                    pc_in_range;
   logic                    target_misaligned;

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign pc_plus4          = PC + DATA_WIDTH'(4);
   assign pc_in_range       = (PC >= RESET_PC) && (PC <= LAST_PC) && (PC[1:0] == 2'b00);
   assign target_misaligned = (RedirectTarget[1:0] != 2'b00);

   // Fault detection outranks redirect, which outranks stall, which outranks fetch.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = PC;
      instr_p1_nxt = IFID_Instruction;
      pc4_p1_nxt   = IFID_PCPlus4;
      vld_p1_nxt   = IFID_Valid;
      fault_nxt    = Fault;
      faddr_nxt    = FaultAddr;
      cnt_nxt      = InstrCount;
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (RedirectValid && target_misaligned) begin
               state_nxt  = FAULT;
               fault_nxt  = 1'b1;
               faddr_nxt  = RedirectTarget;
               vld_p1_nxt = 1'b0;
            end else if (!RedirectValid && !pc_in_range) begin
               state_nxt  = FAULT;
               fault_nxt  = 1'b1;
               faddr_nxt  = PC;
               vld_p1_nxt = 1'b0;
            end else if (RedirectValid) begin
               pc_nxt       = RedirectTarget;
               instr_p1_nxt = '0;
               pc4_p1_nxt   = '0;
               vld_p1_nxt   = 1'b0;
            end else if (!Stall) begin
               pc_nxt       = pc_plus4;
               instr_p1_nxt = Instruction;
               pc4_p1_nxt   = pc_plus4;
               vld_p1_nxt   = 1'b1;
               cnt_nxt      = sat_inc(InstrCount);
            end
         end
         FAULT: begin
            fault_nxt  = 1'b1;
            vld_p1_nxt = 1'b0;
         end
         default: state_nxt = BOOT;
      endcase
   end

   // Stage boundary: PC (fetch) and IF/ID registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= BOOT;
         PC               <= RESET_PC;
         IFID_Instruction <= '0;
         IFID_PCPlus4     <= '0;
         IFID_Valid       <= 1'b0;
         Fault            <= 1'b0;
         FaultAddr        <= '0;
         InstrCount       <= '0;
      end else begin
         state            <= state_nxt;
         PC               <= pc_nxt;
         IFID_Instruction <= instr_p1_nxt;
         IFID_PCPlus4     <= pc4_p1_nxt;
         IFID_Valid       <= vld_p1_nxt;
         Fault            <= fault_nxt;
         FaultAddr        <= faddr_nxt;
         InstrCount       <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random
// stall/redirect traffic compared against a behavioural fetch model.
module tb_instruction_fetch_unit;

   localparam int          DEPTH = 32;
   localparam logic [31:0] RPC   = 32'h0040_0000;
   localparam logic [31:0] LAST  = RPC + 32'(4 * (DEPTH - 1));
   localparam logic [145:0] RST_VEC = {RPC, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 16'h0};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Stall = 1'b0;
   logic        RedirectValid = 1'b0;
   logic [31:0] RedirectTarget = '0;
   logic [31:0] Instruction;
   logic [31:0] PC, IFID_Instruction, IFID_PCPlus4, FaultAddr;
   logic        IFID_Valid, Fault;
   logic [15:0] InstrCount;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [DEPTH];

   // behavioural model state
   bit          m_boot, m_fault, m_vld;
   logic [31:0] m_pc, m_instr, m_pc4, m_faddr;
   int          m_fetches;

   instruction_fetch_unit #(
      .DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .RESET_PC(RPC)
   ) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .RedirectValid(RedirectValid),
      .RedirectTarget(RedirectTarget), .Instruction(Instruction), .PC(PC),
      .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
      .IFID_Valid(IFID_Valid), .Fault(Fault), .FaultAddr(FaultAddr),
      .InstrCount(InstrCount)
   );

   always #5 clk = ~clk;

   // program memory answers combinationally for the current PC
   assign Instruction = (PC >= RPC && PC <= LAST) ? mem[5'((PC - RPC) >> 2)] : 32'hDEAD_BEEF;

   function automatic logic [145:0] dut_vec();
      return {PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Fault, FaultAddr, InstrCount};
   endfunction

   function automatic logic [145:0] mdl_vec();
      logic [15:0] c;
      c = (m_fetches > 65535) ? 16'hFFFF : 16'(m_fetches);
      return {m_pc, m_instr, m_pc4, m_vld, m_fault, m_faddr, c};
   endfunction

   task automatic model_reset();
      m_boot = 1; m_fault = 0; m_vld = 0;
      m_pc = RPC; m_instr = 0; m_pc4 = 0; m_faddr = 0; m_fetches = 0;
   endtask

   task automatic model_step();
      bit inr;
      if (m_boot) begin
         m_boot = 0;
      end else if (!m_fault) begin
         inr = (m_pc >= RPC) && (m_pc <= LAST) && (m_pc[1:0] == 2'b00);
         if (RedirectValid && RedirectTarget[1:0] != 2'b00) begin
            m_fault = 1; m_faddr = RedirectTarget; m_vld = 0;
         end else if (!RedirectValid && !inr) begin
            m_fault = 1; m_faddr = m_pc; m_vld = 0;
         end else if (RedirectValid) begin
            m_pc = RedirectTarget; m_instr = 0; m_pc4 = 0; m_vld = 0;
         end else if (!Stall) begin
            m_instr = mem[int'((m_pc - RPC) >> 2)];
            m_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            m_vld = 1;
            m_fetches++;
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      Stall = 0; RedirectValid = 0; RedirectTarget = 0;
      reset = 0;
      model_reset();
      #2;
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_reset();
      reset = 1;
      #2 reset = 0;
      #2;
      n_tests++;
      if (dut_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_values: got %h expected %h", dut_vec(), RST_VEC);
      end
      model_reset();
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_boot();
      step();
      n_tests++;
      if (PC !== RPC || IFID_Valid !== 1'b0 || dut_vec() !== mdl_vec()) begin
         n_fail++;
         $display("FAIL boot_cycle: got %h expected %h", dut_vec(), mdl_vec());
      end
      step();
      n_tests++;
      if (IFID_Instruction !== mem[0] || IFID_PCPlus4 !== 32'h0040_0004 ||
          PC !== 32'h0040_0004 || InstrCount !== 16'd1 || IFID_Valid !== 1'b1) begin
         n_fail++;
         $display("FAIL first_fetch: got %h expected %h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_stall();
      step();
      Stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++;
         if (PC !== 32'h0040_0008 || InstrCount !== 16'd2 || IFID_Instruction !== mem[1] ||
             IFID_PCPlus4 !== 32'h0040_0008 || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
         end
      end
      Stall = 0;
      step();
      n_tests++;
      if (PC !== 32'h0040_000C || InstrCount !== 16'd3) begin
         n_fail++;
         $display("FAIL stall_release: got PC %h cnt %0d expected PC 0040000c cnt 3", PC, InstrCount);
      end
   endtask

   task automatic test_redirect_stall();
      RedirectValid = 1; RedirectTarget = 32'h0040_0010; Stall = 1;
      step();
      n_tests++;
      if (PC !== 32'h0040_0010 || IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 ||
          IFID_PCPlus4 !== 32'h0 || InstrCount !== 16'd3) begin
         n_fail++;
         $display("FAIL redirect_squash: got %h expected %h", dut_vec(), mdl_vec());
      end
      RedirectValid = 0; Stall = 0;
      step();
      n_tests++;
      if (IFID_PCPlus4 !== 32'h0040_0014 || IFID_Instruction !== mem[4] || IFID_Valid !== 1'b1) begin
         n_fail++;
         $display("FAIL redirect_fetch: got %h expected %h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_range_fault();
      apply_reset();
      step();
      for (int i = 0; i < DEPTH; i++) step();
      n_tests++;
      if (PC !== 32'h0040_0080 || Fault !== 1'b0 || IFID_Instruction !== mem[DEPTH-1] ||
          InstrCount !== 16'(DEPTH)) begin
         n_fail++;
         $display("FAIL last_word_fetch: got %h expected %h", dut_vec(), mdl_vec());
      end
      step();
      n_tests++;
      if (Fault !== 1'b1 || FaultAddr !== 32'h0040_0080 || IFID_Valid !== 1'b0 || PC !== 32'h0040_0080) begin
         n_fail++;
         $display("FAIL range_fault: got %h expected %h", dut_vec(), mdl_vec());
      end
      for (int i = 0; i < 5; i++) begin
         Stall = 1'($urandom);
         RedirectValid = 1;
         RedirectTarget = RPC + 32'(4 * $urandom_range(0, DEPTH - 1));
         step();
         n_tests++;
         if (PC !== 32'h0040_0080 || Fault !== 1'b1 || FaultAddr !== 32'h0040_0080 ||
             IFID_Valid !== 1'b0 || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL fault_absorbing[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   task automatic test_misaligned();
      apply_reset();
      step(); step(); step();
      RedirectValid = 1; RedirectTarget = 32'h0040_0006;
      step();
      RedirectValid = 0;
      n_tests++;
      if (Fault !== 1'b1 || FaultAddr !== 32'h0040_0006 || PC !== 32'h0040_0008 || IFID_Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL misaligned_fault: got %h expected %h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_out_of_range_target();
      logic [31:0] tgt [2];
      tgt[0] = 32'hFFFF_FFFC;
      tgt[1] = RPC - 32'd4;
      for (int k = 0; k < 2; k++) begin
         apply_reset();
         step();
         RedirectValid = 1; RedirectTarget = tgt[k];
         step();
         RedirectValid = 0;
         n_tests++;
         if (PC !== tgt[k] || Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL far_redirect[%0d]: got PC %h fault %b expected PC %h fault 0", k, PC, Fault, tgt[k]);
         end
         step();
         n_tests++;
         if (Fault !== 1'b1 || FaultAddr !== tgt[k] || PC !== tgt[k] || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL far_fault[%0d]: got %h expected %h", k, dut_vec(), mdl_vec());
         end
      end
   endtask

   task automatic test_random();
      int r;
      apply_reset();
      step();
      for (int i = 0; i < 400; i++) begin
         if (m_fault && $urandom_range(0, 3) == 0) begin
            apply_reset();
            step();
         end
         Stall = ($urandom_range(0, 99) < 30);
         r = $urandom_range(0, 99);
         RedirectValid = (r < 15);
         if (r < 2) RedirectTarget = RPC + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, DEPTH - 1));
         else if (r < 3) RedirectTarget = RPC + 32'(4 * DEPTH);
         else RedirectTarget = RPC + 32'(4 * $urandom_range(0, DEPTH - 1));
         step();
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
         end
      end
      Stall = 0; RedirectValid = 0;
   endtask

   task automatic test_reset_in_fault();
      apply_reset();
      step(); step();
      RedirectValid = 1; RedirectTarget = 32'h0040_0001;
      step();
      n_tests++;
      if (Fault !== 1'b1) begin
         n_fail++;
         $display("FAIL enter_fault: got %b expected 1", Fault);
      end
      Stall = 1;
      #3 reset = 0;
      #1;
      n_tests++;
      if (dut_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_in_fault: got %h expected %h", dut_vec(), RST_VEC);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (dut_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_held: got %h expected %h", dut_vec(), RST_VEC);
      end
      model_reset();
      Stall = 0; RedirectValid = 0;
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_saturation();
      int guard;
      apply_reset();
      step();
      guard = 0;
      while (m_fetches < 65535 && guard < 80000) begin
         RedirectValid = (m_pc > LAST);
         RedirectTarget = RPC;
         step();
         guard++;
      end
      n_tests++;
      if (guard >= 80000 || InstrCount !== 16'hFFFF || dut_vec() !== mdl_vec()) begin
         n_fail++;
         $display("FAIL count_reach_max: got %h expected %h", dut_vec(), mdl_vec());
      end
      for (int i = 0; i < 4; i++) begin
         RedirectValid = (m_pc > LAST);
         RedirectTarget = RPC;
         step();
         n_tests++;
         if (InstrCount !== 16'hFFFF || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL count_saturate[%0d]: got %h expected ffff", i, InstrCount);
         end
      end
      RedirectValid = 0;
      #2 reset = 0;
      #1;
      n_tests++;
      if (dut_vec() !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_after_sat: got %h expected %h", dut_vec(), RST_VEC);
      end
      model_reset();
      @(negedge clk);
      reset = 1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      model_reset();
      test_reset();
      test_boot();
      test_stall();
      test_redirect_stall();
      test_range_fault();
      test_misaligned();
      test_out_of_range_target();
      test_random();
      test_reset_in_fault();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
